// File: rtl/gf8_poly_reducer.sv
// Sequential GF(2^8) reduction of a 15-bit carry-less product modulo {1, POLY}.
// Reduces one bit position per cycle, from x^14 down to x^8, with a constant 7-cycle reduce phase.
module gf8_poly_reducer #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_res
);

  typedef enum logic [1:0] {IDLE, RED, DONE} state_t;

  state_t      state_reg;
  logic [14:0] work_reg;
  logic [14:0] work_next;
  logic [3:0]  cnt_reg;
  logic [7:0]  res_reg;
  logic        out_valid_reg;

  logic [8:0]  poly_full;
  logic [14:0] poly_mask;
  logic        lead_bit;

  assign poly_full = {1'b1, POLY};
  // Align the polynomial's x^8 term with the bit currently being cleared.
  assign poly_mask = {6'b0, poly_full} << (cnt_reg - 4'd8);
  assign lead_bit  = work_reg[cnt_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_step
      assign work_next[gi] = work_reg[gi] ^ (lead_bit & poly_mask[gi]);
    end
  endgenerate

  // Acceptance in DONE passes straight through from the consumer.
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = out_valid_reg;
  assign out_res   = res_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= 15'h0000;
      cnt_reg       <= 4'd0;
      res_reg       <= 8'h00;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= in_prod;
            cnt_reg   <= 4'd14;
            state_reg <= RED;
          end
        end
        RED: begin
          work_reg <= work_next;
          cnt_reg  <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd8) begin
            res_reg       <= work_next[7:0];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (in_valid) begin
              work_reg  <= in_prod;
              cnt_reg   <= 4'd14;
              state_reg <= RED;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
